// File: rtl/uart_tx.sv
// 8N1 UART transmitter that pops bytes from the TX FIFO and shifts them out LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [BIT_WIDTH-1:0] fifo_pop_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int IW       = $clog2(BIT_WIDTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BIT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic          slot_end;
    logic [IW-1:0] idx_nx;

    assign slot_end = (cnt_q == CNT_LAST);
    assign idx_nx   = idx_q + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The baud counter restarts at every slot boundary and idles at zero.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = (slot_end || state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    data_d  = fifo_pop_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (slot_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_nx;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (slot_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (slot_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = (state_q == S_IDLE) & ~fifo_empty & ~rst;
        tx_d     = tx_q;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (fifo_pop) tx_d = 1'b0;
            end
            S_START: begin
                if (slot_end) tx_d = data_q[0];
            end
            S_DATA: begin
                if (slot_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = ^data_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d = data_q[idx_nx];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (slot_end) tx_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (slot_end) done_d = 1'b1;
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a queue-backed FIFO stand-in.
// Per-cycle logs of tx/tx_done/tx_busy/fifo_pop are checked after each scenario.
module tb_uart_tx;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL   = NB * DIV;
    localparam int LOGN = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_pop_data = 8'h00;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] fq[$];
    logic       txlog[LOGN];
    logic       donelog[LOGN];
    logic       busylog[LOGN];
    logic       poplog[LOGN];
    int         cyc;
    int         checks;
    int         errors;

    uart_tx #(
        .CLK_FREQ (100),
        .BAUD     (10),
        .BIT_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_pop_data(fifo_pop_data),
        .fifo_pop     (fifo_pop),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        fifo_empty    = (fq.size() == 0);
        fifo_pop_data = fifo_empty ? 8'h00 : fq[0];
    endtask

    task automatic logc();
        if (cyc < LOGN) begin
            txlog[cyc]   = tx;
            donelog[cyc] = tx_done;
            busylog[cyc] = tx_busy;
        end
    endtask

    task automatic restart();
        for (int i = 0; i < LOGN; i++) begin
            txlog[i]   = 1'b0;
            donelog[i] = 1'b0;
            busylog[i] = 1'b0;
            poplog[i]  = 1'b0;
        end
        cyc = 0;
        drive();
        logc();
    endtask

    task automatic tick();
        logic       p;
        logic [7:0] d;
        #1;
        p = fifo_pop;
        if (cyc < LOGN) poplog[cyc] = p;
        @(posedge clk);
        #1;
        if (p && fq.size() > 0) d = fq.pop_front();
        cyc++;
        drive();
        logc();
    endtask

    function automatic int find_pop(int from);
        for (int i = from; i < cyc && i < LOGN; i++)
            if (poplog[i]) return i;
        return -1;
    endfunction

    // sel: 0 pops, 1 done pulses, 2 busy cycles, 3 cycles with tx low
    function automatic int cnt(int sel, int a, int b);
        int s = 0;
        for (int i = a; i < b && i < LOGN; i++) begin
            case (sel)
                0: s += int'(poplog[i]);
                1: s += int'(donelog[i]);
                2: s += int'(busylog[i]);
                default: s += int'(!txlog[i]);
            endcase
        end
        return s;
    endfunction

    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(string tag, int n, logic [7:0] b);
        check({tag, "_idle_at_pop"}, txlog[n], 1);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("%s_s%0d_first", tag, k),
                  txlog[n + 1 + DIV * k], frame_bit(b, k));
            check($sformatf("%s_s%0d_last", tag, k),
                  txlog[n + DIV * (k + 1)], frame_bit(b, k));
        end
        check({tag, "_done"}, donelog[n + FL + 1], 1);
        check({tag, "_done_early"}, donelog[n + FL], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, n1, n2;
        checks = 0;
        errors = 0;

        // reset held 3 cycles with data waiting
        rst = 1'b1;
        fq.push_back(8'h55);
        restart();
        repeat (3) tick();
        check("rst_no_pop", cnt(0, 0, 3), 0);
        rst = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_first_pop", fifo_pop, 1);
        repeat (FL + 20) tick();
        n = find_pop(0);
        check("b55_pop_cycle", n, 3);
        if (n < 0) n = 0;
        check_frame("b55", n, 8'h55);
        check("b55_pops", cnt(0, 0, cyc), 1);
        check("b55_dones", cnt(1, 0, cyc), 1);
        check("b55_busy_pop", busylog[n], 0);
        check("b55_busy_start", busylog[n + 1], 1);
        check("b55_busy_stop", busylog[n + FL], 1);
        check("b55_busy_done", busylog[n + FL + 1], 0);

        // back-to-back with FIFO pre-filled
        fq.push_back(8'hA3);
        fq.push_back(8'h0F);
        restart();
        repeat (2 * FL + 20) tick();
        n1 = find_pop(0);
        check("b2b_pop1", n1, 0);
        if (n1 < 0) n1 = 0;
        n2 = find_pop(n1 + 1);
        check("b2b_period", n2 - n1, FL + 1);
        if (n2 < 0) n2 = n1 + FL + 1;
        check("b2b_pop_on_done", donelog[n2], 1);
        check_frame("bA3", n1, 8'hA3);
        check_frame("b0F", n2, 8'h0F);
        check("b2b_pops", cnt(0, 0, cyc), 2);
        check("b2b_dones", cnt(1, 0, cyc), 2);

        // empty FIFO
        restart();
        repeat (500) tick();
        check("empty_pops", cnt(0, 0, 500), 0);
        check("empty_tx_low", cnt(3, 0, 501), 0);
        check("empty_busy", cnt(2, 0, 501), 0);

        // reset during data bit 3 of 0xFF
        fq.push_back(8'hFF);
        fq.push_back(8'h12);
        restart();
        for (int i = 0; i < 50 && find_pop(0) < 0; i++) tick();
        n = find_pop(0);
        check("mid_pop_found", n >= 0, 1);
        if (n < 0) n = 0;
        while (cyc < n + 1 + 4 * DIV + 4 && cyc < 200) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_nopop", poplog[cyc - 1], 0);
        rst = 1'b0;
        repeat (FL + 30) tick();
        n2 = find_pop(n + 1);
        check("mid_next_pop", n2, cyc - FL - 30);
        if (n2 < 0) n2 = n + 1;
        check("mid_no_done", cnt(1, n, n2 + 1), 0);
        check_frame("b12", n2, 8'h12);
        check("mid_pops", cnt(0, 0, cyc), 2);

`ifdef UART_TX_PARITY_EN
        fq.push_back(8'h07);
        fq.push_back(8'h03);
        restart();
        repeat (2 * FL + 20) tick();
        n1 = find_pop(0);
        if (n1 < 0) n1 = 0;
        n2 = find_pop(n1 + 1);
        check("par_period", n2 - n1, 111);
        if (n2 < 0) n2 = n1 + 111;
        check("par07_bit", txlog[n1 + 1 + 9 * DIV + 5], 1);
        check("par03_bit", txlog[n2 + 1 + 9 * DIV + 5], 0);
        check("par07_done", donelog[n1 + 111], 1);
        check_frame("b07", n1, 8'h07);
        check_frame("b03", n2, 8'h03);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
